// File: rtl/debug_led_pkg.sv
// Shared definitions for the debug LED blink-code block: state encoding,
// default timing and counter-width helpers.
package debug_led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int DEF_CLK_HZ    = 50_000_000;
  localparam int DEF_TICK_HZ   = 1000;
  localparam int DEF_ON_TICKS  = 200;
  localparam int DEF_OFF_TICKS = 200;
  localparam int DEF_GAP_TICKS = 1000;
  localparam int DEF_CODE_W    = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk_50 down to a one-cycle tick every DIV cycles; clr restarts the
// count so a phase begun on clr lasts a whole number of DIV periods.
module tick_prescaler
  import debug_led_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk_50,
  input  logic resetn,
  input  logic clr,
  output logic tick
);

  localparam int W = cnt_w(DIV - 1);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_50 or negedge resetn) begin
    if (!resetn)                  cnt <= '0;
    else if (clr || cnt == LAST)  cnt <= '0;
    else                          cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/debug_led_blink_code.sv
// Debug LED blink-code emitter: accepts a pulse count over valid/ready and
// blinks it out followed by a long dark gap. Define DEBUG_LED_PWM_EN to add
// a duty input that dims the LED during each pulse.
module debug_led_blink_code
  import debug_led_pkg::*;
#(
  parameter int CLK_HZ    = DEF_CLK_HZ,
  parameter int TICK_HZ   = DEF_TICK_HZ,
  parameter int ON_TICKS  = DEF_ON_TICKS,
  parameter int OFF_TICKS = DEF_OFF_TICKS,
  parameter int GAP_TICKS = DEF_GAP_TICKS,
  parameter int CODE_W    = DEF_CODE_W
) (
  input  logic              clk_50,
  input  logic              resetn,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code,
`ifdef DEBUG_LED_PWM_EN
  input  logic [7:0]        duty,
`endif
  output logic              code_ready,
  output logic              busy,
  output logic              debug_led
);

  // DIV must come out >= 1; CLK_HZ below TICK_HZ is not a supported build.
  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int TMAX = (ON_TICKS > OFF_TICKS)
                      ? ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS)
                      : ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
  localparam int TW   = cnt_w(TMAX);

  state_t            state, state_next;
  logic [TW-1:0]     tick_cnt;
  logic [TW-1:0]     phase_last;
  logic [CODE_W-1:0] remaining;
  logic              tick, clr, phase_done, accept;

  assign accept     = code_valid && code_ready && (code != '0);
  assign phase_done = tick && (tick_cnt == phase_last);
  // Holding clr through IDLE and pulsing it on every transition aligns the
  // first tick of each phase exactly DIV cycles after entry.
  assign clr        = (state == IDLE) || (state_next != state);

  tick_prescaler #(.DIV(DIV)) u_presc (
    .clk_50 (clk_50),
    .resetn (resetn),
    .clr    (clr),
    .tick   (tick)
  );

  always_comb begin
    phase_last = '0;
    case (state)
      ON:      phase_last = TW'(ON_TICKS - 1);
      OFF:     phase_last = TW'(OFF_TICKS - 1);
      GAP:     phase_last = TW'(GAP_TICKS - 1);
      default: phase_last = '0;
    endcase
  end

  always_ff @(posedge clk_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      code_ready <= 1'b1;
      tick_cnt   <= '0;
      remaining  <= '0;
    end else begin
      state      <= state_next;
      code_ready <= (state_next == IDLE);
      if (clr)       tick_cnt <= '0;
      else if (tick) tick_cnt <= tick_cnt + 1'b1;
      if (accept)                         remaining <= code;
      else if (state == ON && phase_done) remaining <= remaining - 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept)     state_next = ON;
      ON:   if (phase_done) state_next = (remaining == CODE_W'(1)) ? GAP : OFF;
      OFF:  if (phase_done) state_next = ON;
      GAP:  if (phase_done) state_next = IDLE;
      default:              state_next = IDLE;
    endcase
  end

`ifdef DEBUG_LED_PWM_EN
  logic [7:0] pwm_cnt;

  always_ff @(posedge clk_50 or negedge resetn) begin
    if (!resetn) pwm_cnt <= '0;
    else         pwm_cnt <= pwm_cnt + 8'd1;
  end

  always_comb begin
    debug_led = 1'b0;
    if (state == ON) debug_led = (pwm_cnt < duty);
  end
`else
  always_comb begin
    debug_led = 1'b0;
    if (state == ON) debug_led = 1'b1;
  end
`endif

  assign busy = !code_ready;

endmodule

// File: tb/tb_debug_led_blink_code.sv
// Bench for debug_led_blink_code: a per-cycle LED/ready schedule model plus
// directed literal checks and randomized handshakes.
module tb_debug_led_blink_code;

  localparam int DIV  = 10;
  localparam int ONT  = 2;
  localparam int OFFT = 3;
  localparam int GAPT = 5;

  logic       clk_50 = 1'b0;
  logic       resetn = 1'b0;
  logic       code_valid = 1'b0;
  logic [3:0] code = '0;
  logic       code_ready, busy, debug_led;
`ifdef DEBUG_LED_PWM_EN
  logic [7:0] duty = 8'd255;
`endif

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  chk_en = 1'b0;
  bit  q[$];       // expected "in a pulse" flag for each upcoming cycle
  int  pwm = 0;

  always #5 clk_50 = ~clk_50;

  debug_led_blink_code #(
    .CLK_HZ(10000), .TICK_HZ(1000), .ON_TICKS(ONT), .OFF_TICKS(OFFT),
    .GAP_TICKS(GAPT), .CODE_W(4)
  ) dut (
    .clk_50     (clk_50),
    .resetn     (resetn),
    .code_valid (code_valid),
    .code       (code),
`ifdef DEBUG_LED_PWM_EN
    .duty       (duty),
`endif
    .code_ready (code_ready),
    .busy       (busy),
    .debug_led  (debug_led)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_led();
    if (q.size() == 0) return 1'b0;
`ifdef DEBUG_LED_PWM_EN
    return q[0] && (pwm < int'(duty));
`else
    return q[0];
`endif
  endfunction

  // Model: a handshake with code N schedules N lit runs of ON*DIV cycles,
  // separated by OFF*DIV dark cycles, then GAP*DIV dark cycles; busy while
  // the schedule is non-empty.
  initial forever begin
    @(posedge clk_50 or negedge resetn);
    if (!resetn) begin
      q.delete();
      pwm = 0;
    end else begin
      if (q.size() != 0) void'(q.pop_front());
      else if (code_valid && code != 0) begin
        for (int p = 1; p <= int'(code); p++) begin
          repeat (ONT * DIV) q.push_back(1'b1);
          if (p < int'(code)) repeat (OFFT * DIV) q.push_back(1'b0);
        end
        repeat (GAPT * DIV) q.push_back(1'b0);
      end
      pwm = (pwm + 1) % 256;
    end
  end

  always @(negedge clk_50) begin
    if (chk_en) begin
      check("led",   debug_led,  exp_led());
      check("ready", code_ready, q.size() == 0);
      check("busy",  busy,       q.size() != 0);
    end
  end

  task automatic send_pulse(input logic [3:0] c);
    @(negedge clk_50);
    code = c; code_valid = 1'b1;
    @(negedge clk_50);
    code_valid = 1'b0;
  endtask

  task automatic send_hold(input logic [3:0] c, input bit scramble);
    @(negedge clk_50);
    code_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (code_ready) begin
        code = c;
        @(negedge clk_50);
        code_valid = 1'b0;
        return;
      end
      code = scramble ? 4'($urandom) : c;
      @(negedge clk_50);
    end
    check("hs_timeout", 0, 1);
    code_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      if (code_ready) return;
      @(negedge clk_50);
    end
    check("idle_timeout", 0, 1);
  endtask

  task automatic rises_until_ready(output int n);
    bit prev;
    prev = 1'b0; n = 0;
    for (int i = 0; i < 3000; i++) begin
      if (code_ready) return;
      if (debug_led && !prev) n++;
      prev = debug_led;
      @(negedge clk_50);
    end
    check("rise_timeout", 0, 1);
  endtask

  initial begin
    int runs[$];
    int n, total, len;
    bit cur, seen_hi, seen_nr;

    repeat (3) @(negedge clk_50);
    check("rst_led", debug_led, 0);
    check("rst_ready", code_ready, 1);
    check("rst_busy", busy, 0);
    resetn = 1'b1;
    chk_en = 1'b1;
    repeat (4) @(negedge clk_50);

`ifndef DEBUG_LED_PWM_EN
    // Code 3: literal run lengths 20/30/20/30/20/50, ready after 170 cycles.
    send_pulse(4'd3);
    cur = debug_led; len = 0; total = 0;
    check("c3_first_lit", cur, 1);
    for (int i = 0; i < 2000; i++) begin
      if (code_ready) break;
      if (debug_led == cur) len++;
      else begin runs.push_back(len); cur = debug_led; len = 1; end
      total++;
      @(negedge clk_50);
    end
    runs.push_back(len);
    check("c3_nruns", runs.size(), 6);
    if (runs.size() == 6) begin
      check("c3_on1", runs[0], 20);  check("c3_off1", runs[1], 30);
      check("c3_on2", runs[2], 20);  check("c3_off2", runs[3], 30);
      check("c3_on3", runs[4], 20);  check("c3_gap",  runs[5], 50);
    end
    check("c3_ready_lat", total, 170);
`endif

    // Code 0 is swallowed without any activity.
    send_pulse(4'd0);
    seen_hi = 1'b0; seen_nr = 1'b0;
    repeat (40) begin
      if (debug_led) seen_hi = 1'b1;
      if (!code_ready || busy) seen_nr = 1'b1;
      @(negedge clk_50);
    end
    check("c0_led_never", seen_hi, 0);
    check("c0_ready_held", seen_nr, 0);

`ifndef DEBUG_LED_PWM_EN
    // A code presented while busy waits for ready and is then taken once.
    send_pulse(4'd2);
    code = 4'd5; code_valid = 1'b1;
    rises_until_ready(n);
    check("busy_first_pulses", n, 2);
    @(negedge clk_50);
    code_valid = 1'b0;
    rises_until_ready(n);
    check("busy_second_pulses", n, 5);
    repeat (3) @(negedge clk_50);
`endif

    // Reset landing inside the second ON phase of code 4.
    send_pulse(4'd4);
    repeat (54) @(negedge clk_50);
    @(posedge clk_50);
    #2 resetn = 1'b0;
    #1;
    check("midrst_led", debug_led, 0);
    check("midrst_ready", code_ready, 1);
    check("midrst_busy", busy, 0);
    @(negedge clk_50);
    resetn = 1'b1;
    seen_hi = 1'b0;
    repeat (100) begin
      if (debug_led || busy) seen_hi = 1'b1;
      @(negedge clk_50);
    end
    check("midrst_quiet", seen_hi, 0);

`ifdef DEBUG_LED_PWM_EN
    duty = 8'd64;
    send_pulse(4'd1);
    wait_idle();
    duty = 8'd0;
    send_pulse(4'd1);
    seen_hi = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (code_ready) break;
      if (debug_led) seen_hi = 1'b1;
      @(negedge clk_50);
    end
    check("pwm_duty0_dark", seen_hi, 0);
`endif

    // Randomized handshakes, with the code scrambled while waiting for ready.
    for (int t = 0; t < 25; t++) begin
`ifdef DEBUG_LED_PWM_EN
      duty = 8'($urandom);
`endif
      send_hold(($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 6)),
                1'($urandom));
      if ($urandom_range(0, 1) == 1) wait_idle();
      repeat ($urandom_range(0, 5)) @(negedge clk_50);
    end
    wait_idle();
    repeat (5) @(negedge clk_50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
